mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/ariane_pkg.sv | 32 +++
 rtl/fifo_v3.sv | 69 ++++++
 rtl/mult_arbiter.sv | 155 +++++++++++++++
 tb/tb_mult_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg (slice): shared types for the multiplier arbiter.
//   XLEN / TRANS_ID_BITS : core datapath and scoreboard id widths
//   fu_op                : functional-unit operator encoding
//   requester_e          : which requester owns a multiplier issue slot
//   inflight_t           : the one-deep record of the request currently in the multiplier
package ariane_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;
  // Widest id/tag the in-flight record can hold; AccTagWidth must not exceed it.
  localparam int unsigned MAX_TAG_BITS  = 8;

  typedef enum logic [3:0] {
    ADD, SUB, MUL, MULH, MULHU, MULHSU, MULW, DIV
  } fu_op;

  typedef enum logic {
    CORE = 1'b0,
    ACC  = 1'b1
  } requester_e;

  typedef struct packed {
    logic                    valid;
    requester_e              owner;
    logic [MAX_TAG_BITS-1:0] id;    // core trans_id or accelerator tag, zero-extended
  } inflight_t;

  function automatic logic is_mul_op(fu_op op);
    return op inside {MUL, MULH, MULHU, MULHSU, MULW};
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: small synchronous FIFO (common_cells compatible subset).
//   clk_i/rst_ni : clock, async active-low reset (pointers and count cleared)
//   flush_i      : synchronous empty
//   full_o/empty_o/usage_o : status; usage_o is the full occupancy count
//   data_i/push_i: write side; data_o/pop_i: read side
// With FALL_THROUGH=0 data_o is the storage entry at the read pointer, so a
// pushed word becomes visible the cycle after the push.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH:0]   usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] LastPtr = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [ADDR_DEPTH:0]   DepthC  = (ADDR_DEPTH + 1)'(DEPTH);

  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  dtype                  mem_q [DEPTH];
  logic                  bypass, do_push, do_pop;

  // Fall-through with an empty FIFO hands data_i straight to the reader.
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
  assign full_o  = (cnt_q == DepthC);
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign usage_o = cnt_q;
  assign data_o  = (FALL_THROUGH && cnt_q == '0) ? data_i : mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o && !bypass;
  assign do_pop  = pop_i && (cnt_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the count decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one external 1-cycle multiplier between the core and
// an accelerator.
//   core_*     : request (valid/ready) and response (no backpressure), flushed by clr_i
//   acc_*      : request (valid/ready) and response through a small FIFO with ready
//   mul_*_o    : issue to the multiplier; mul_valid_i/mul_result_i one cycle later
// Round-robin between the two on contention. The accelerator is only granted
// when a FIFO slot is guaranteed for its result (stored + in-flight < depth),
// which is why the FIFO can never overflow. clr_i kills only core traffic.
module mult_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned AccTagWidth = 4,
  parameter int unsigned RspDepth    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  // core request / response
  input  logic                     core_valid_i,
  output logic                     core_ready_o,
  input  fu_op                     core_op_i,
  input  logic [XLEN-1:0]          core_a_i,
  input  logic [XLEN-1:0]          core_b_i,
  input  logic [TRANS_ID_BITS-1:0] core_trans_id_i,
  output logic                     core_rsp_valid_o,
  output logic [XLEN-1:0]          core_rsp_result_o,
  output logic [TRANS_ID_BITS-1:0] core_rsp_trans_id_o,
  // accelerator request / response
  input  logic                     acc_valid_i,
  output logic                     acc_ready_o,
  input  fu_op                     acc_op_i,
  input  logic [XLEN-1:0]          acc_a_i,
  input  logic [XLEN-1:0]          acc_b_i,
  input  logic [AccTagWidth-1:0]   acc_tag_i,
  output logic                     acc_rsp_valid_o,
  input  logic                     acc_rsp_ready_i,
  output logic [XLEN-1:0]          acc_rsp_result_o,
  output logic [AccTagWidth-1:0]   acc_rsp_tag_o,
  // multiplier
  output logic                     mul_valid_o,
  output fu_op                     mul_op_o,
  output logic [XLEN-1:0]          mul_a_o,
  output logic [XLEN-1:0]          mul_b_o,
  output logic [TRANS_ID_BITS-1:0] mul_trans_id_o,
  input  logic                     mul_valid_i,
  input  logic [XLEN-1:0]          mul_result_i
);

  localparam int unsigned CntW  = ((RspDepth > 1) ? $clog2(RspDepth) : 1) + 1;
  localparam int unsigned UsedW = CntW + 1;
  localparam int unsigned RspW  = XLEN + AccTagWidth;

  requester_e       rr_q, rr_d;
  inflight_t        inflight_q, inflight_d;
  logic             core_elig, acc_elig, contested, gnt_core, gnt_acc;
  logic             acc_inflight, fifo_full, fifo_empty, fifo_pop;
  logic [CntW-1:0]  fifo_usage;
  logic [UsedW-1:0] credits_used;
  logic [RspW-1:0]  fifo_wdata, fifo_rdata;

  // ---------------- arbitration ----------------
  assign acc_inflight = inflight_q.valid && (inflight_q.owner == ACC);
  assign credits_used = UsedW'(fifo_usage) + UsedW'(acc_inflight);

  // rst_ni gating keeps mul_valid_o and the readies low while in reset.
  assign core_elig = rst_ni && core_valid_i && !clr_i;
  assign acc_elig  = rst_ni && acc_valid_i && (credits_used < UsedW'(RspDepth));
  assign contested = core_elig && acc_elig;

  always_comb begin
    gnt_core = core_elig;
    gnt_acc  = acc_elig;
    rr_d     = rr_q;
    if (contested) begin
      gnt_core = (rr_q == CORE);
      gnt_acc  = (rr_q == ACC);
      rr_d     = (rr_q == CORE) ? ACC : CORE;
    end
  end

  assign core_ready_o   = gnt_core;
  assign acc_ready_o    = gnt_acc;
  assign mul_valid_o    = gnt_core || gnt_acc;
  assign mul_op_o       = gnt_acc ? acc_op_i : core_op_i;
  assign mul_a_o        = gnt_acc ? acc_a_i  : core_a_i;
  assign mul_b_o        = gnt_acc ? acc_b_i  : core_b_i;
  assign mul_trans_id_o = gnt_core ? core_trans_id_i : '0;

  // ---------------- in-flight record ----------------
  always_comb begin
    inflight_d = '0;
    if (gnt_core) begin
      inflight_d.valid = 1'b1;
      inflight_d.owner = CORE;
      inflight_d.id    = MAX_TAG_BITS'(core_trans_id_i);
    end else if (gnt_acc) begin
      inflight_d.valid = 1'b1;
      inflight_d.owner = ACC;
      inflight_d.id    = MAX_TAG_BITS'(acc_tag_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      rr_q       <= CORE;
    end else begin
      inflight_q <= inflight_d;
      rr_q       <= rr_d;
    end
  end

  // ---------------- core response ----------------
  assign core_rsp_valid_o    = inflight_q.valid && (inflight_q.owner == CORE) && !clr_i;
  assign core_rsp_result_o   = mul_result_i;
  assign core_rsp_trans_id_o = inflight_q.id[TRANS_ID_BITS-1:0];

  // ---------------- accelerator response buffer ----------------
  assign fifo_wdata = {mul_result_i, inflight_q.id[AccTagWidth-1:0]};
  assign fifo_pop   = acc_rsp_valid_o && acc_rsp_ready_i;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (RspW),
    .DEPTH        (RspDepth)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (fifo_wdata),
    .push_i  (acc_inflight),
    .data_o  (fifo_rdata),
    .pop_i   (fifo_pop)
  );

  assign acc_rsp_valid_o                   = !fifo_empty;
  assign {acc_rsp_result_o, acc_rsp_tag_o} = fifo_rdata;

  // ---------------- protocol checks ----------------
  a_mul_latency: assert property (@(posedge clk_i) disable iff (!rst_ni)
    inflight_q.valid |-> mul_valid_i);
  a_core_op: assert property (@(posedge clk_i) disable iff (!rst_ni)
    core_valid_i |-> is_mul_op(core_op_i));
  a_acc_op: assert property (@(posedge clk_i) disable iff (!rst_ni)
    acc_valid_i |-> is_mul_op(acc_op_i));
  a_no_overrun: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(acc_inflight && fifo_full));
  // An idle slot is always fully cleared.
  a_idle_clear: assert property (@(posedge clk_i) disable iff (!rst_ni)
    inflight_q.valid || (inflight_q.id == '0 && inflight_q.owner == CORE));

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a 1-cycle multiplier model.
module tb_mult_arbiter;
  import ariane_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n, clr;
  logic                     core_valid, core_ready;
  fu_op                     core_op, acc_op, mul_op;
  logic [XLEN-1:0]          core_a, core_b, acc_a, acc_b, mul_a, mul_b, mul_res;
  logic [TRANS_ID_BITS-1:0] core_id, core_rsp_id, mul_tid;
  logic                     core_rsp_valid, acc_valid, acc_ready, acc_rsp_valid, acc_rsp_ready;
  logic [XLEN-1:0]          core_rsp_result, acc_rsp_result;
  logic [3:0]               acc_tag, acc_rsp_tag;
  logic                     mul_valid_o, mul_vld;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.AccTagWidth(4), .RspDepth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .core_valid_i(core_valid), .core_ready_o(core_ready), .core_op_i(core_op),
    .core_a_i(core_a), .core_b_i(core_b), .core_trans_id_i(core_id),
    .core_rsp_valid_o(core_rsp_valid), .core_rsp_result_o(core_rsp_result),
    .core_rsp_trans_id_o(core_rsp_id),
    .acc_valid_i(acc_valid), .acc_ready_o(acc_ready), .acc_op_i(acc_op),
    .acc_a_i(acc_a), .acc_b_i(acc_b), .acc_tag_i(acc_tag),
    .acc_rsp_valid_o(acc_rsp_valid), .acc_rsp_ready_i(acc_rsp_ready),
    .acc_rsp_result_o(acc_rsp_result), .acc_rsp_tag_o(acc_rsp_tag),
    .mul_valid_o(mul_valid_o), .mul_op_o(mul_op), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_trans_id_o(mul_tid), .mul_valid_i(mul_vld), .mul_result_i(mul_res)
  );

  // 1-cycle multiplier (only MUL is exercised: low XLEN bits of the product)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_vld <= 1'b0;
      mul_res <= '0;
    end else begin
      mul_vld <= mul_valid_o;
      mul_res <= mul_a * mul_b;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    core_valid = 1'b1; core_op = MUL; core_a = '0; core_b = '0; core_id = '0;
    acc_valid = 1'b1; acc_op = MUL; acc_a = '0; acc_b = '0; acc_tag = '0;
    acc_rsp_ready = 1'b0;
    #12;
    // reset state: everything quiet even with requests pending
    chk("rst_mulv",  mul_valid_o, 0);
    chk("rst_crdy",  core_ready, 0);
    chk("rst_ardy",  acc_ready, 0);
    chk("rst_crsp",  core_rsp_valid, 0);
    chk("rst_arsp",  acc_rsp_valid, 0);
    core_valid = 1'b0; acc_valid = 1'b0; rst_n = 1'b1;

    // core only: 6*7, id 3
    step; core_valid = 1'b1; core_a = 6; core_b = 7; core_id = 3; #1;
    chk("co_rdy",  core_ready, 1);
    chk("co_mulv", mul_valid_o, 1);
    chk("co_mtid", mul_tid, 3);
    step; core_valid = 1'b0; #1;
    chk("co_rspv", core_rsp_valid, 1);
    chk("co_res",  core_rsp_result, 42);
    chk("co_tid",  core_rsp_id, 3);
    step; #1;
    chk("co_idle", core_rsp_valid, 0);

    // flush kills the response of the previous grant and blocks a new one
    step; core_valid = 1'b1; core_a = 3; core_b = 5; core_id = 2; #1;
    chk("fl_rdy",  core_ready, 1);
    step; clr = 1'b1; core_id = 6; #1;
    chk("fl_rsp",  core_rsp_valid, 0);
    chk("fl_blk",  core_ready, 0);
    chk("fl_mulv", mul_valid_o, 0);
    step; clr = 1'b0; core_valid = 1'b0; #1;
    chk("fl_idle", core_rsp_valid, 0);

    // contention, rr starts at core
    step; acc_rsp_ready = 1'b1; core_valid = 1'b1; acc_valid = 1'b1;
    core_a = 4; core_b = 5; core_id = 1; acc_a = 3; acc_b = 3; acc_tag = 1; #1;
    chk("c0_core", core_ready, 1);
    chk("c0_acc",  acc_ready, 0);
    step; #1;
    chk("c1_core", core_ready, 0);
    chk("c1_acc",  acc_ready, 1);
    chk("c1_mtid", mul_tid, 0);
    chk("c1_mula", mul_a, 3);
    chk("c1_crsp", core_rsp_result, 20);
    step; core_a = 2; acc_a = 5; acc_tag = 3; #1;
    chk("c2_core", core_ready, 1);
    chk("c2_acc",  acc_ready, 0);
    step; #1;
    chk("c3_core", core_ready, 0);
    chk("c3_acc",  acc_ready, 1);
    chk("c3_arv",  acc_rsp_valid, 1);
    chk("c3_ares", acc_rsp_result, 9);
    chk("c3_atag", acc_rsp_tag, 1);
    chk("c3_cres", core_rsp_result, 10);
    step; core_valid = 1'b0; acc_valid = 1'b0; #1;
    chk("c4_arv",  acc_rsp_valid, 0);
    step; #1;
    chk("c5_arv",  acc_rsp_valid, 1);
    chk("c5_ares", acc_rsp_result, 15);
    chk("c5_atag", acc_rsp_tag, 3);
    step; acc_rsp_ready = 1'b0; #1;
    chk("c6_arv",  acc_rsp_valid, 0);

    // backpressure: only two credits
    step; acc_valid = 1'b1; acc_a = 1; acc_b = 7; acc_tag = 4; #1;
    chk("bp0_rdy", acc_ready, 1);
    step; acc_a = 2; acc_tag = 5; #1;
    chk("bp1_rdy", acc_ready, 1);
    step; acc_a = 3; acc_tag = 6; #1;
    chk("bp2_rdy", acc_ready, 0);
    chk("bp2_mulv", mul_valid_o, 0);
    chk("bp2_arv", acc_rsp_valid, 1);
    chk("bp2_tag", acc_rsp_tag, 4);
    chk("bp2_res", acc_rsp_result, 7);
    step; acc_rsp_ready = 1'b1; #1;
    chk("bp3_rdy", acc_ready, 0);
    step; acc_rsp_ready = 1'b0; #1;
    chk("bp4_rdy", acc_ready, 1);
    chk("bp4_tag", acc_rsp_tag, 5);

    // flush with tag 5 pending and tag 6 in flight
    step; acc_valid = 1'b0; clr = 1'b1; #1;
    step; clr = 1'b0; #1;
    chk("fa_arv",  acc_rsp_valid, 1);
    chk("fa_tag",  acc_rsp_tag, 5);
    chk("fa_res",  acc_rsp_result, 14);

    // reset with two buffered entries
    rst_n = 1'b0; acc_valid = 1'b1; #1;
    chk("rm_arv",  acc_rsp_valid, 0);
    chk("rm_crsp", core_rsp_valid, 0);
    chk("rm_ardy", acc_ready, 0);
    step; acc_valid = 1'b0; rst_n = 1'b1;
    step; acc_valid = 1'b1; acc_a = 4; acc_b = 4; acc_tag = 9; #1;
    chk("pr_arv",  acc_rsp_valid, 0);
    chk("pr_ardy", acc_ready, 1);
    step; acc_valid = 1'b0; #1;
    chk("pr_arv1", acc_rsp_valid, 0);
    step; #1;
    chk("pr_arv2", acc_rsp_valid, 1);
    chk("pr_res",  acc_rsp_result, 16);
    chk("pr_tag",  acc_rsp_tag, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
